fft_row_loader: RTL and testbench

Upstream feeder for `main_cordic_fft`, the 32-point parallel FFT. It accepts complex samples serially over a valid/ready stream and packs 32 of them into a double-buffered row. It presents the row as two stable 512-bit buses wired to `xin1..xin32` / `yin1..yin32`, holds the row for a fixed settle window, then pulses `capture` so the downstream stage samples `xout`/`yout`. Row and frame counters let the phase-correlation controller sequence row and column passes.

---
 rtl/fft_row_loader.sv | 178 +++++++++++++++++
 tb/tb_fft_row_loader.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_row_loader.sv
// fft_row_loader
// Serial-to-parallel front end for the 32-point parallel FFT. Complex samples
// arrive one per cycle over a valid/ready stream and are packed into a fill
// buffer. A completed row is copied onto two wide, stable buses that drive the
// FFT's xin/yin inputs. The row is held for HOLD cycles so the combinational
// FFT can settle, and then a one-cycle capture pulse tells the downstream
// stage to sample the FFT outputs. While one row is held, the next row can
// fill, so rows stream back to back without a gap in row_valid.
//
// Ports:
//   clock      - single rising-edge clock
//   reset_n    - asynchronous active-low reset
//   in_valid   - in_re/in_im carry a sample this cycle
//   in_re      - real part, two's complement
//   in_im      - imaginary part, two's complement
//   in_ready   - loader accepts a sample this cycle (fill buffer not full)
//   xin_bus    - held real row, sample k at bits [DW*k +: DW]
//   yin_bus    - held imaginary row, same packing
//   row_valid  - buses carry a row inside its hold window
//   capture    - one-cycle pulse in the last cycle of the hold window
//   row_idx    - index of the row currently on the buses
//   frame_last - capture pulse belonging to row ROWS-1
module fft_row_loader #(
  parameter int N    = 32,
  parameter int DW   = 16,
  parameter int HOLD = 64,
  parameter int ROWS = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic [DW-1:0]           in_re,
  input  logic [DW-1:0]           in_im,
  output logic                    in_ready,
  output logic [N*DW-1:0]         xin_bus,
  output logic [N*DW-1:0]         yin_bus,
  output logic                    row_valid,
  output logic                    capture,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    frame_last
);

  localparam int WW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(HOLD);
  localparam int RW = $clog2(ROWS);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WW-1:0]   wptr;
  logic            fill_full;
  logic [HW-1:0]   hcnt;
  logic [RW-1:0]   next_idx;
  logic [DW-1:0]   fill_re [N];
  logic [DW-1:0]   fill_im [N];
  logic            xfer;
  logic            hold_end;
  logic            load;

  // A full fill buffer is the only thing that can stop the input stream, so
  // in_ready comes straight from that flag with no combinational path from
  // the hold side.
  assign in_ready   = !fill_full;
  assign xfer       = in_valid && !fill_full;

  // hold_end marks the last cycle of the hold window. A pending full row is
  // loaded either immediately when nothing is held, or on the edge that ends
  // the current window, which keeps row_valid continuous between rows.
  assign hold_end   = (state == S_HOLD) && (hcnt == HW'(HOLD - 1));
  assign load       = fill_full && ((state == S_IDLE) || hold_end);

  assign row_valid  = (state == S_HOLD);
  assign capture    = hold_end;
  assign frame_last = hold_end && (row_idx == RW'(ROWS - 1));

  // Write pointer and fill-full flag. A transfer and a load never coincide:
  // transfers need the buffer not full, loads need it full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr      <= '0;
      fill_full <= 1'b0;
    end else if (xfer) begin
      if (wptr == WW'(N - 1)) begin
        wptr      <= '0;
        fill_full <= 1'b1;
      end else begin
        wptr <= wptr + 1'b1;
      end
    end else if (load) begin
      fill_full <= 1'b0;
    end
  end

  // Fill buffer storage. It holds no meaning until a full row has been
  // written, so it carries no reset.
  always_ff @(posedge clock) begin
    if (xfer) begin
      fill_re[wptr] <= in_re;
      fill_im[wptr] <= in_im;
    end
  end

  // Output row buses. They change only on a load, so in IDLE they keep
  // presenting the last row that was held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xin_bus <= '0;
      yin_bus <= '0;
    end else if (load) begin
      for (int k = 0; k < N; k++) begin
        xin_bus[DW*k +: DW] <= fill_re[k];
        yin_bus[DW*k +: DW] <= fill_im[k];
      end
    end
  end

  // Hold-side state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a load always (re)enters HOLD; the end of a window
  // without a waiting row drops back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (load) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_end && !load) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Hold-window counter, restarted by every load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
    end else if (load) begin
      hcnt <= '0;
    end else if (hold_end) begin
      hcnt <= '0;
    end else if (state == S_HOLD) begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Row numbering. next_idx names the row that will be loaded next and wraps
  // after the last row of a frame; row_idx follows the row on the buses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_idx  <= '0;
      next_idx <= '0;
    end else if (load) begin
      row_idx <= next_idx;
      if (next_idx == RW'(ROWS - 1)) begin
        next_idx <= '0;
      end else begin
        next_idx <= next_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_row_loader.sv
// tb_fft_row_loader
// Self-checking bench for fft_row_loader. Stimulus samples are generated into
// queues; the expected content of row r is simply samples r*N .. r*N+N-1 of
// those queues in arrival order, since the loader is a pure reorder-free
// packer. Timing expectations (hold length, row numbering, frame wrap) are
// derived from row counts and cycle counts.
module tb_fft_row_loader;

  localparam int N    = 32;
  localparam int DW   = 16;
  localparam int HOLD = 64;
  localparam int ROWS = 32;
  localparam int RW   = $clog2(ROWS);

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_re = '0;
  logic [DW-1:0]   in_im = '0;
  logic            in_ready;
  logic [N*DW-1:0] xin_bus;
  logic [N*DW-1:0] yin_bus;
  logic            row_valid;
  logic            capture;
  logic [RW-1:0]   row_idx;
  logic            frame_last;

  int vectors = 0;
  int miscompares = 0;
  bit drive_timeout = 1'b0;

  logic [DW-1:0] stim_re[$];
  logic [DW-1:0] stim_im[$];

  fft_row_loader #(.N(N), .DW(DW), .HOLD(HOLD), .ROWS(ROWS)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_re      (in_re),
    .in_im      (in_im),
    .in_ready   (in_ready),
    .xin_bus    (xin_bus),
    .yin_bus    (yin_bus),
    .row_valid  (row_valid),
    .capture    (capture),
    .row_idx    (row_idx),
    .frame_last (frame_last)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Hard stop in case something wedges the whole run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected completion before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected packed row r built from the stimulus queues.
  function automatic logic [N*DW-1:0] expect_row(input int r, input bit imag);
    logic [N*DW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      v[DW*k +: DW] = imag ? stim_im[r*N+k] : stim_re[r*N+k];
    end
    return v;
  endfunction

  task automatic fill_random(input int count);
    stim_re.delete();
    stim_im.delete();
    for (int i = 0; i < count; i++) begin
      stim_re.push_back(DW'($urandom));
      stim_im.push_back(DW'($urandom));
    end
  endtask

  task automatic do_reset();
    in_valid      = 1'b0;
    in_re         = '0;
    in_im         = '0;
    reset_n       = 1'b0;
    drive_timeout = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Offer one sample, optionally after random idle cycles, and hold it until
  // the loader accepts it. Returns 1 time unit after the accepting edge.
  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input int gap_pct);
    int waitc;
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    waitc    = 0;
    @(negedge clock);
    while (!in_ready && waitc < 1000) begin
      @(negedge clock);
      waitc++;
    end
    if (!in_ready) drive_timeout = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic send_range(input int first, input int count, input int gap_pct);
    for (int i = first; i < first + count; i++) begin
      send(stim_re[i], stim_im[i], gap_pct);
    end
    in_valid = 1'b0;
  endtask

  // Reset values, asynchronous reset in the middle of a fill, and a clean
  // restart at row 0 afterwards.
  task automatic test_reset();
    int cyc;
    do_reset();
    vectors++;
    if (in_ready !== 1'b1 || row_valid !== 1'b0 || capture !== 1'b0 || frame_last !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got rdy=%b rv=%b cap=%b fl=%b, expected 1 0 0 0",
               in_ready, row_valid, capture, frame_last);
    end
    vectors++;
    if (xin_bus !== '0 || yin_bus !== '0 || row_idx !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got row_idx=%0d bus_nonzero=%b, expected 0 0",
               row_idx, (xin_bus != '0) || (yin_bus != '0));
    end

    fill_random(N + 10);
    send_range(0, N + 10, 0);
    #3 reset_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || row_valid !== 1'b0 || capture !== 1'b0 || frame_last !== 1'b0 ||
        row_idx !== '0 || xin_bus !== '0 || yin_bus !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got rdy=%b rv=%b cap=%b idx=%0d bus_nonzero=%b, expected 1 0 0 0 0",
               in_ready, row_valid, capture, row_idx, (xin_bus != '0) || (yin_bus != '0));
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    fill_random(N);
    send_range(0, N, 0);
    cyc = 0;
    @(negedge clock);
    while (!capture && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    vectors++;
    if (!capture || row_idx !== '0 || xin_bus !== expect_row(0, 0)) begin
      miscompares++;
      $display("[TB] FAIL reset_restart: got cap=%b idx=%0d x=%h, expected 1 0 %h",
               capture, row_idx, xin_bus, expect_row(0, 0));
    end
    vectors++;
    if (drive_timeout) begin
      miscompares++;
      $display("[TB] FAIL reset_drive: got accept timeout, expected every sample accepted");
    end
  endtask

  // One row with exact latency checks around load and capture.
  task automatic test_single_row();
    logic [N*DW-1:0] held;
    bit window_bad;
    do_reset();
    stim_re.delete();
    stim_im.delete();
    for (int k = 0; k < N; k++) begin
      stim_re.push_back((k < 8) ? DW'(255) : DW'(0));
      stim_im.push_back(DW'(0));
    end
    send_range(0, N, 0);

    // Cycle right after the N-th accepting edge: buffer full, not yet loaded.
    vectors++;
    if (in_ready !== 1'b0 || row_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_full: got rdy=%b rv=%b, expected 0 0", in_ready, row_valid);
    end
    @(posedge clock);
    #1;
    vectors++;
    if (row_valid !== 1'b1 || in_ready !== 1'b1 || row_idx !== '0) begin
      miscompares++;
      $display("[TB] FAIL single_load: got rv=%b rdy=%b idx=%0d, expected 1 1 0",
               row_valid, in_ready, row_idx);
    end
    held = {{(N-8)*DW{1'b0}}, {8{16'h00FF}}};
    vectors++;
    if (xin_bus !== held) begin
      miscompares++;
      $display("[TB] FAIL single_xin: got %h expected %h", xin_bus, held);
    end
    vectors++;
    if (yin_bus !== '0) begin
      miscompares++;
      $display("[TB] FAIL single_yin: got %h expected 0", yin_bus);
    end

    window_bad = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      if (capture !== (i == HOLD - 1) || row_valid !== 1'b1 || frame_last !== 1'b0 ||
          xin_bus !== held) window_bad = 1'b1;
      @(posedge clock);
      #1;
    end
    vectors++;
    if (window_bad) begin
      miscompares++;
      $display("[TB] FAIL single_window: got irregular hold window, expected capture only in cycle %0d", HOLD);
    end
    vectors++;
    if (row_valid !== 1'b0 || capture !== 1'b0 || xin_bus !== held) begin
      miscompares++;
      $display("[TB] FAIL single_after: got rv=%b cap=%b bus_kept=%b, expected 0 0 1",
               row_valid, capture, xin_bus === held);
    end
  endtask

  // Three rows streamed continuously: row_valid stays high, buses change only
  // right after capture, and in_ready stalls while a full row waits.
  task automatic test_back_to_back();
    do_reset();
    stim_re.delete();
    stim_im.delete();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) begin
        stim_re.push_back(DW'(r * 100 + k));
        stim_im.push_back(DW'(r * 100 + k + 50));
      end
    end
    fork
      send_range(0, 3 * N, 0);
      begin
        int caps = 0;
        int cyc = 0;
        bit started = 1'b0;
        bit prev_cap = 1'b0;
        bit gap_bad = 1'b0;
        bit early_bad = 1'b0;
        bit ready_bad = 1'b0;
        logic [N*DW-1:0] prev_x = '0;
        while (caps < 3 && cyc < 2000) begin
          @(negedge clock);
          cyc++;
          if (!started) begin
            if (row_valid) started = 1'b1;
          end else begin
            if (!row_valid) gap_bad = 1'b1;
            if (xin_bus !== prev_x && !prev_cap) early_bad = 1'b1;
            if (prev_cap && in_ready !== 1'b1) ready_bad = 1'b1;
          end
          prev_x = xin_bus;
          if (started && capture) begin
            vectors++;
            if (xin_bus !== expect_row(caps, 0) || yin_bus !== expect_row(caps, 1) ||
                row_idx !== RW'(caps)) begin
              miscompares++;
              $display("[TB] FAIL b2b_row%0d: got idx=%0d x=%h, expected idx=%0d x=%h",
                       caps, row_idx, xin_bus, caps, expect_row(caps, 0));
            end
            if (caps < 2 && in_ready !== 1'b0) ready_bad = 1'b1;
            caps++;
          end
          prev_cap = capture;
        end
        vectors++;
        if (caps != 3) begin
          miscompares++;
          $display("[TB] FAIL b2b_count: got %0d captures, expected 3", caps);
        end
        vectors++;
        if (gap_bad) begin
          miscompares++;
          $display("[TB] FAIL b2b_gap: got row_valid low between rows, expected continuous");
        end
        vectors++;
        if (early_bad) begin
          miscompares++;
          $display("[TB] FAIL b2b_stable: got bus change outside capture edge, expected stable");
        end
        vectors++;
        if (ready_bad) begin
          miscompares++;
          $display("[TB] FAIL b2b_ready: got in_ready wrong around load, expected 0 at capture, 1 after");
        end
      end
    join
  endtask

  // Random idle gaps on the input; rows must arrive in order, intact, and
  // exactly as many as were sent.
  task automatic test_backpressure();
    do_reset();
    fill_random(4 * N);
    fork
      send_range(0, 4 * N, 40);
      begin
        for (int r = 0; r < 4; r++) begin
          int cyc = 0;
          @(negedge clock);
          while (!capture && cyc < 3000) begin
            @(negedge clock);
            cyc++;
          end
          vectors++;
          if (!capture || xin_bus !== expect_row(r, 0)) begin
            miscompares++;
            $display("[TB] FAIL bp_x%0d: got cap=%b x=%h, expected 1 %h", r, capture, xin_bus, expect_row(r, 0));
          end
          vectors++;
          if (!capture || yin_bus !== expect_row(r, 1)) begin
            miscompares++;
            $display("[TB] FAIL bp_y%0d: got cap=%b y=%h, expected 1 %h", r, capture, yin_bus, expect_row(r, 1));
          end
        end
      end
    join
    repeat (HOLD + 5) @(negedge clock);
    vectors++;
    if (row_valid !== 1'b0 || in_ready !== 1'b1 || drive_timeout) begin
      miscompares++;
      $display("[TB] FAIL bp_drain: got rv=%b rdy=%b timeout=%b, expected 0 1 0",
               row_valid, in_ready, drive_timeout);
    end
  endtask

  // 33 rows: frame_last only with row ROWS-1's capture; row numbering wraps.
  task automatic test_frame_wrap();
    do_reset();
    fill_random((ROWS + 1) * N);
    fork
      send_range(0, (ROWS + 1) * N, 0);
      begin
        bit stray = 1'b0;
        for (int r = 0; r <= ROWS; r++) begin
          int cyc = 0;
          @(negedge clock);
          while (!capture && cyc < 3000) begin
            if (frame_last) stray = 1'b1;
            @(negedge clock);
            cyc++;
          end
          vectors++;
          if (!capture || row_idx !== RW'(r % ROWS) || frame_last !== (r % ROWS == ROWS - 1) ||
              xin_bus !== expect_row(r, 0)) begin
            miscompares++;
            $display("[TB] FAIL wrap_row%0d: got cap=%b idx=%0d fl=%b, expected 1 %0d %b",
                     r, capture, row_idx, frame_last, r % ROWS, (r % ROWS == ROWS - 1));
          end
        end
        vectors++;
        if (stray) begin
          miscompares++;
          $display("[TB] FAIL wrap_stray: got frame_last outside capture, expected none");
        end
      end
    join
  endtask

  // Negative imaginary parts must reach the bus as exact two's complement.
  task automatic test_complex();
    int cyc;
    logic [DW-1:0] neg;
    do_reset();
    stim_re.delete();
    stim_im.delete();
    for (int k = 0; k < N; k++) begin
      stim_re.push_back(DW'(k));
      stim_im.push_back(DW'(-k));
    end
    send_range(0, N, 0);
    cyc = 0;
    @(negedge clock);
    while (!capture && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    for (int k = 0; k < N; k++) begin
      neg = ~DW'(k) + 1'b1;
      vectors++;
      if (yin_bus[DW*k +: DW] !== neg || xin_bus[DW*k +: DW] !== DW'(k)) begin
        miscompares++;
        $display("[TB] FAIL complex_k%0d: got re=%h im=%h, expected re=%h im=%h",
                 k, xin_bus[DW*k +: DW], yin_bus[DW*k +: DW], DW'(k), neg);
      end
    end
  endtask

  initial begin
    $display("[TB] starting fft_row_loader bench");
    test_reset();
    test_single_row();
    test_back_to_back();
    test_backpressure();
    test_frame_wrap();
    test_complex();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
